// File: rtl/ksk_mem_axi_drain.sv
// Drains a contiguous range of wide memory lines into AXI-width beats on a valid/ready stream.
// Two-entry ping-pong line buffer with read credits so returning data always has a free entry.
module ksk_mem_axi_drain #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_LANE       = 128,
  parameter int unsigned NB_PIPE        = 1,
  parameter int unsigned KSK_MEM_DEPTH  = 9216,
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  localparam int unsigned LINE_W        = NUM_LANE * DATA_WIDTH,
  localparam int unsigned LAW           = $clog2(KSK_MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [LAW-1:0]            i_base_line,
  input  logic [LAW:0]              i_num_lines,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_mem_rd_en,
  output logic [LAW-1:0]            o_mem_rd_addr,
  input  logic [LINE_W-1:0]         i_mem_rd_data,
  output logic                      o_axi_valid,
  input  logic                      i_axi_ready,
  output logic [AXI_DATA_WIDTH-1:0] o_axi_data,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_addr,
  output logic                      o_axi_last
);

  localparam int unsigned BEATS = LINE_W / AXI_DATA_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PD    = NB_PIPE + 1;

  typedef enum logic {StIdle = 1'b0, StRun = 1'b1} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [LAW-1:0]      r_base;
  logic [LAW:0]        r_num;
  logic [LAW:0]        r_issued;
  logic [LAW:0]        r_drained;
  logic [BW-1:0]       r_beat;
  logic [PD-1:0]       r_pipe;
  logic [1:0]          r_occ;
  logic [1:0]          w_occ_next;
  logic                r_wr_sel;
  logic                r_rd_sel;
  logic [LINE_W-1:0]   r_buf [2];
  logic                r_done;

  int unsigned         w_used;
  logic                w_rd_en;
  logic                w_cap;
  logic                w_valid;
  logic                w_hs;
  logic                w_beat_last;
  logic                w_line_last;
  logic                w_free;
  logic                w_done_next;
  logic [LAW:0]        w_line;
  logic [AXI_DATA_WIDTH-1:0] w_beat_data;

  // Credits: reads still in the capture pipe plus lines parked in the buffer.
  always_comb begin
    w_used = 0;
    for (int i = 0; i < int'(PD); i++) begin
      w_used = w_used + 32'(r_pipe[i]);
    end
    w_used = w_used + 32'(r_occ[0]) + 32'(r_occ[1]);
  end

  assign w_rd_en     = (r_state == StRun) && (r_issued != r_num) && (w_used < 2);
  assign w_cap       = r_pipe[PD-1];
  assign w_valid     = r_occ[r_rd_sel];
  assign w_hs        = w_valid && i_axi_ready;
  assign w_beat_last = (r_beat == BW'(BEATS - 1));
  assign w_line_last = (r_drained == (r_num - 1'b1));
  assign w_free      = w_hs && w_beat_last;
  assign w_line      = {1'b0, r_base} + r_drained;
  assign w_beat_data = r_buf[r_rd_sel][32'(r_beat) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (i_num_lines == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = StRun;
          end
        end
      end
      StRun: begin
        if (w_free && w_line_last) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_occ_next = r_occ;
    if (w_cap) w_occ_next[r_wr_sel] = 1'b1;
    if (w_free) w_occ_next[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_base    <= '0;
      r_num     <= '0;
      r_issued  <= '0;
      r_drained <= '0;
      r_beat    <= '0;
      r_pipe    <= '0;
      r_occ     <= '0;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_buf     <= '{default: '0};
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_pipe  <= PD'({r_pipe, w_rd_en});
      r_occ   <= w_occ_next;
      if ((r_state == StIdle) && i_start) begin
        r_base    <= i_base_line;
        r_num     <= i_num_lines;
        r_issued  <= '0;
        r_drained <= '0;
        r_beat    <= '0;
      end
      if (w_rd_en) r_issued <= r_issued + 1'b1;
      if (w_cap) begin
        r_buf[r_wr_sel] <= i_mem_rd_data;
        r_wr_sel        <= ~r_wr_sel;
      end
      if (w_hs) begin
        if (w_beat_last) begin
          r_beat    <= '0;
          r_drained <= r_drained + 1'b1;
          r_rd_sel  <= ~r_rd_sel;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

  assign o_busy        = (r_state == StRun);
  assign o_done        = r_done;
  assign o_mem_rd_en   = w_rd_en;
  assign o_mem_rd_addr = r_base + r_issued[LAW-1:0];
  assign o_axi_valid   = w_valid;
  assign o_axi_data    = w_valid ? w_beat_data : '0;
  assign o_axi_addr    = AXI_ADDR_WIDTH'(w_line) * AXI_ADDR_WIDTH'(BEATS)
                         + AXI_ADDR_WIDTH'(r_beat);
  assign o_axi_last    = w_valid && w_beat_last && w_line_last;

endmodule

// File: tb/tb_ksk_mem_axi_drain.sv
// Directed bench for ksk_mem_axi_drain: hashed memory image, fixed-latency read model,
// beat scoreboard with stall-stability and credit tracking.
module tb_ksk_mem_axi_drain;

  localparam int LINE_W = 8192;
  localparam int LAW    = 14;
  localparam int ADW    = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [LAW-1:0]    i_base_line;
  logic [LAW:0]      i_num_lines;
  logic              o_busy;
  logic              o_done;
  logic              o_mem_rd_en;
  logic [LAW-1:0]    o_mem_rd_addr;
  logic [LINE_W-1:0] i_mem_rd_data;
  logic              o_axi_valid;
  logic              i_axi_ready;
  logic [ADW-1:0]    o_axi_data;
  logic [63:0]       o_axi_addr;
  logic              o_axi_last;

  ksk_mem_axi_drain dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_base_line   (i_base_line),
    .i_num_lines   (i_num_lines),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_axi_valid   (o_axi_valid),
    .i_axi_ready   (i_axi_ready),
    .o_axi_data    (o_axi_data),
    .o_axi_addr    (o_axi_addr),
    .o_axi_last    (o_axi_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_seed = 1;
  int rmode    = 0;  // 0: ready high, 1: ready 30% random, 2: ready low

  logic           h0_en = 1'b0, h1_en = 1'b0;
  logic [LAW-1:0] h0_addr = '0, h1_addr = '0;

  int start_cyc, exp_base, exp_num, nbeats, rd_cnt, valid_cnt, done_cnt, done_rel;
  int first_v, last_rel, outstanding, max_out, stab_err;
  logic           prev_stall;
  logic [ADW-1:0] p_data;
  logic [63:0]    p_addr;
  logic           p_last;

  task automatic check_eq(input string tag, input logic [ADW-1:0] got, input logic [ADW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mem_line(input int addr);
    logic [LINE_W-1:0] l;
    logic [31:0] x;
    for (int w = 0; w < LINE_W / 32; w++) begin
      x = 32'(addr) * 32'h9E3779B1 + 32'(w) * 32'h7F4A7C15 + 32'(mem_seed) * 32'h85EBCA6B;
      x = x ^ (x >> 15);
      x = x * 32'h2C1B3C6D;
      x = x ^ (x >> 13);
      l[w*32 +: 32] = x;
    end
    return l;
  endfunction

  task automatic tick();
    logic [LINE_W-1:0] line;
    logic [ADW-1:0] exp_d;
    int k;
    @(negedge clk);
    cyc++;
    case (rmode)
      0: i_axi_ready = 1'b1;
      1: i_axi_ready = ($urandom_range(0, 99) < 30);
      default: i_axi_ready = 1'b0;
    endcase
    // Data for a read returns two cycles after its strobe.
    if (h1_en) i_mem_rd_data = mem_line(int'(h1_addr));
    else i_mem_rd_data = {256{32'hBADC0FFE}};
    h1_en = h0_en; h1_addr = h0_addr;
    h0_en = o_mem_rd_en; h0_addr = o_mem_rd_addr;
    if (o_mem_rd_en) begin
      rd_cnt++;
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
    end
    if (o_axi_valid) begin
      valid_cnt++;
      if (first_v < 0) first_v = cyc - start_cyc;
    end
    if (prev_stall) begin
      if (!(o_axi_valid && o_axi_data == p_data && o_axi_addr == p_addr && o_axi_last == p_last))
        stab_err++;
    end
    if (o_axi_valid && i_axi_ready) begin
      k = nbeats % 16;
      line = mem_line(exp_base + nbeats / 16);
      exp_d = line[k*ADW +: ADW];
      check_eq($sformatf("beat%0d_data", nbeats), o_axi_data, exp_d);
      check_eq($sformatf("beat%0d_addr", nbeats), ADW'(o_axi_addr), ADW'(exp_base * 16 + nbeats));
      check_eq($sformatf("beat%0d_last", nbeats), ADW'(o_axi_last),
               ADW'(nbeats == exp_num * 16 - 1));
      last_rel = cyc - start_cyc;
      if (k == 15) outstanding--;
      nbeats++;
    end
    prev_stall = o_axi_valid && !i_axi_ready;
    p_data = o_axi_data; p_addr = o_axi_addr; p_last = o_axi_last;
    if (o_done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
      check_eq("busy_low_at_done", ADW'(o_busy), '0);
    end
  endtask

  task automatic start_cmd(input int b, input int n);
    i_base_line = LAW'(b);
    i_num_lines = (LAW+1)'(n);
    i_start     = 1'b1;
    start_cyc = cyc; exp_base = b; exp_num = n;
    nbeats = 0; rd_cnt = 0; valid_cnt = 0; done_cnt = 0; done_rel = -1;
    first_v = -1; last_rel = -1; outstanding = 0; max_out = 0; stab_err = 0;
    prev_stall = 1'b0;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check_eq({tag, "_done_seen"}, ADW'(done_cnt != 0), ADW'(1));
    repeat (4) tick();
    check_eq({tag, "_done_once"}, ADW'(done_cnt), ADW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, ADW'(o_busy), '0);
    check_eq({tag, "_done"}, ADW'(o_done), '0);
    check_eq({tag, "_rd_en"}, ADW'(o_mem_rd_en), '0);
    check_eq({tag, "_rd_addr"}, ADW'(o_mem_rd_addr), '0);
    check_eq({tag, "_valid"}, ADW'(o_axi_valid), '0);
    check_eq({tag, "_last"}, ADW'(o_axi_last), '0);
    check_eq({tag, "_data"}, o_axi_data, '0);
    check_eq({tag, "_addr"}, ADW'(o_axi_addr), '0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_base_line = '0; i_num_lines = '0;
    i_axi_ready = 1'b1; i_mem_rd_data = '0;
    exp_base = 0; exp_num = 0; nbeats = 0; done_cnt = 0; start_cyc = 0;
    prev_stall = 1'b0; outstanding = 0; max_out = 0; rd_cnt = 0; valid_cnt = 0;
    first_v = -1; stab_err = 0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Four lines, ready always high: back-to-back beats.
    rmode = 0;
    start_cmd(0, 4);
    wait_done("t1", 200);
    check_eq("t1_beats", ADW'(nbeats), ADW'(64));
    check_eq("t1_first_valid_cyc", ADW'(first_v), ADW'(4));
    check_eq("t1_last_beat_cyc", ADW'(last_rel), ADW'(67));
    check_eq("t1_done_cyc", ADW'(done_rel), ADW'(68));
    check_eq("t1_reads", ADW'(rd_cnt), ADW'(4));
    check_eq("t1_credit_max_ok", ADW'(max_out <= 2), ADW'(1));

    // One line under random backpressure.
    mem_seed = 2;
    rmode = 1;
    start_cmd(100, 1);
    wait_done("t2", 400);
    check_eq("t2_beats", ADW'(nbeats), ADW'(16));
    check_eq("t2_stall_stable", ADW'(stab_err), '0);
    check_eq("t2_credit_max_ok", ADW'(max_out <= 2), ADW'(1));
    rmode = 0;

    // Zero-length command.
    start_cmd(5, 0);
    wait_done("t3", 20);
    check_eq("t3_done_cyc", ADW'(done_rel), ADW'(1));
    check_eq("t3_reads", ADW'(rd_cnt), '0);
    check_eq("t3_valids", ADW'(valid_cnt), '0);

    // Ready held low: only two lines may be fetched.
    mem_seed = 3;
    rmode = 2;
    start_cmd(40, 8);
    repeat (49) tick();
    check_eq("t4_reads_stalled", ADW'(rd_cnt), ADW'(2));
    check_eq("t4_no_beats_stalled", ADW'(nbeats), '0);
    rmode = 0;
    wait_done("t4", 400);
    check_eq("t4_beats", ADW'(nbeats), ADW'(128));
    check_eq("t4_reads", ADW'(rd_cnt), ADW'(8));
    check_eq("t4_credit_max_ok", ADW'(max_out <= 2), ADW'(1));

    // Reset during beat 5 of line 2.
    mem_seed = 4;
    start_cmd(0, 8);
    for (int i = 0; i < 300 && nbeats < 38; i++) tick();
    check_eq("t5_reached_beat37", ADW'(nbeats), ADW'(38));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t5_post_rst");
    valid_cnt = 0; done_cnt = 0;
    repeat (10) tick();
    check_eq("t5_no_valid_after_rst", ADW'(valid_cnt), '0);
    check_eq("t5_no_done_after_rst", ADW'(done_cnt), '0);
    mem_seed = 5;
    start_cmd(3, 1);
    wait_done("t5_fresh", 100);
    check_eq("t5_fresh_beats", ADW'(nbeats), ADW'(16));

    // Second start while busy is ignored.
    mem_seed = 6;
    start_cmd(20, 2);
    tick();
    i_base_line = LAW'(500); i_num_lines = (LAW+1)'(5); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("t6", 200);
    check_eq("t6_beats", ADW'(nbeats), ADW'(32));
    check_eq("t6_reads", ADW'(rd_cnt), ADW'(2));
    check_eq("t6_done_cyc", ADW'(done_rel), ADW'(36));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ksk_mem_axi_drain.md
# ksk_mem_axi_drain

Read-side drain engine for the wide key-switching-key / vector-lane memory. On command it reads a contiguous range of wide lines (NUM_LANE×DATA_WIDTH bits) through the fixed-latency VP read port. Each line is split into AXI_DATA_WIDTH beats and streamed out on a valid/ready beat interface toward the AXI write-back path. It is the inverse of the AXI-side beat packing used by the memory's write port: beat k of line L carries the same bits that AXI write address L·BEATS+k deposits.

## Interface
Parameters:
- DATA_WIDTH, 64, lane word width
- NUM_LANE, 128, lanes per memory line
- NB_PIPE, 1, memory read pipeline stages
- KSK_MEM_DEPTH, 9216, lines in memory
- AXI_DATA_WIDTH, 512, beat width
- AXI_ADDR_WIDTH, 64, beat address width
- derived: LINE_W = NUM_LANE·DATA_WIDTH; BEATS = LINE_W/AXI_DATA_WIDTH (16); LAW = $clog2(KSK_MEM_DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  command strobe, sampled only in IDLE
- i_base_line  in  LAW  first line to read
- i_num_lines  in  LAW+1  line count, 0..KSK_MEM_DEPTH
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle completion pulse
- o_mem_rd_en  out  1  memory read strobe
- o_mem_rd_addr  out  LAW  memory line address
- i_mem_rd_data  in  LINE_W  line data, valid NB_PIPE+1 cycles after rd_en
- o_axi_valid  out  1  beat valid
- i_axi_ready  in  1  beat accept
- o_axi_data  out  AXI_DATA_WIDTH  beat payload
- o_axi_addr  out  AXI_ADDR_WIDTH  beat address = line·BEATS + beat index, zero-extended
- o_axi_last  out  1  final beat of the command

## Operation
- FSM: IDLE, RUN.
  - IDLE→RUN on i_start with i_num_lines≠0. Base and count are latched.
  - i_start with i_num_lines=0: o_done pulses the next cycle; the FSM stays in IDLE and issues no reads.
  - RUN→IDLE on the handshake of the final beat. o_done pulses the following cycle.
  - i_start is ignored while in RUN.
- Line buffer: two entries. A read is issued only when (reads in flight + occupied entries) < 2, so returning data always has a free entry. The memory port has no backpressure.
- Capture: a shift register of depth NB_PIPE+1 tracks rd_en. Its tail writes i_mem_rd_data into the next entry (ping-pong).
- Read addresses increment by 1 from base, with no wrap. base+num_lines > KSK_MEM_DEPTH is a caller error; the address is truncated to LAW bits.
- Serialization: beat k = entry[k·AXI_DATA_WIDTH +: AXI_DATA_WIDTH], k ascending 0..BEATS-1.
  - The entry frees on the handshake of beat BEATS-1.
  - Beats of the next entry follow without a bubble.
- o_axi_last = valid beat is beat BEATS-1 of line num_lines-1.
- Counters: reads issued (LAW+1 bits), lines drained (LAW+1 bits), beat index ($clog2(BEATS) bits).

## Timing
- Reset values: o_busy=0, o_done=0, o_mem_rd_en=0, o_mem_rd_addr=0, o_axi_valid=0, o_axi_last=0, o_axi_data=0, o_axi_addr=0. Buffer, capture pipe, and counters are cleared.
- Reset mid-operation:
  - The FSM returns to IDLE and no o_done is issued.
  - In-flight memory data returning after reset is discarded, because the capture pipe is cleared.
- Start accepted at cycle 0:
  - o_busy=1 and the first o_mem_rd_en are at cycle 1.
  - Data arrives at cycle NB_PIPE+2 and is captured.
  - o_axi_valid=1 from cycle NB_PIPE+3.
- Second read issues at cycle 2, when a credit is free.
- AXI rule: once o_axi_valid=1, valid, data, addr and last hold until i_axi_ready=1. Valid never depends combinationally on ready.
- Throughput: with i_axi_ready held high and NB_PIPE+2 ≤ BEATS, one beat per cycle. N lines finish their last beat at cycle NB_PIPE+2+BEATS·N, and o_done follows one cycle later.
- o_busy falls in the same cycle o_done is high.

## Test plan
- Preload the memory with random lines; start with base=0, num_lines=4 and ready always high.
  - Expected: 64 beats on consecutive cycles, addresses 0..63.
  - Beat k matches line k>>4, slice k[3:0]; last is high only on beat 63.
  - o_done pulses at cycle 68.
- base=100, num_lines=1, ready toggling on a random 30% duty cycle.
  - Expected: 16 beats at addresses 1600..1615, data held stable while stalled.
  - Never more than 2 reads in flight or buffered.
- num_lines=0 → o_done pulses at cycle 1, with no rd_en and no valid.
- Hold ready low for 50 cycles after a start with num_lines=8.
  - Expected: exactly 2 rd_en pulses, then no further reads.
  - After ready rises, all 128 beats arrive in order.
- Assert rst for one cycle during beat 5 of line 2.
  - Expected: all outputs are at reset values the next cycle and no o_done.
  - A fresh start with num_lines=1 returns correct data.
- Assert i_start again while busy → ignored; a single command completes and o_done pulses once.
